// File: rtl/pack_send_multi_if.sv
// Packet transmitter bus: start request and payload in, UART line and status out.
// master = the datapath issuing packets, slave = the transmitter.
interface pack_send_multi_if #(
  parameter int NUM_BYTES = 2
);
  logic                   i_en;
  logic [NUM_BYTES*8-1:0] i_data;
  logic                   o_busy;
  logic                   o_Tx_Active;
  logic                   o_Tx_Serial;
  logic                   o_Tx_Done;
  logic                   o_pack_done;

  modport master (
    output i_en, i_data,
    input  o_busy, o_Tx_Active, o_Tx_Serial, o_Tx_Done, o_pack_done
  );

  modport slave (
    input  i_en, i_data,
    output o_busy, o_Tx_Active, o_Tx_Serial, o_Tx_Done, o_pack_done
  );
endinterface

// File: rtl/pack_send_multi.sv
// Captures NUM_BYTES (+ optional XOR checksum) on i_en and sends them as back-to-back 8N1 frames.
// Start bit appears the cycle after an accepted i_en; i_en while busy is dropped, never queued.
module pack_send_multi #(
  parameter int NUM_BYTES    = 2,
  parameter int CLKS_PER_BIT = 434,
  parameter int CHECKSUM_EN  = 0
) (
  input  logic             i_Clock,
  input  logic             i_Rst_n,
  pack_send_multi_if.slave bus
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(NUM_BYTES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_PRE = CW'(CLKS_PER_BIT - 2);
  localparam logic [BW-1:0] LAST    = BW'(NUM_BYTES - 1 + CHECKSUM_EN);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [2:0]             bit_idx;
  logic [BW-1:0]          byte_idx;
  logic [NUM_BYTES*8-1:0] shadow;
  logic [7:0]             chk;
  logic [7:0]             chk_in;
  logic [7:0]             cur_byte;
  logic                   bit_end;
  logic                   tx_serial;
  logic                   tx_active;
  logic                   tx_done;
  logic                   pack_done;
  logic                   busy;

  always_comb begin
    chk_in = '0;
    for (int k = 0; k < NUM_BYTES; k++) chk_in ^= bus.i_data[8*k +: 8];
  end

  // Index NUM_BYTES only occurs with the checksum enabled, so it falls through to chk.
  always_comb begin
    cur_byte = chk;
    for (int k = 0; k < NUM_BYTES; k++) begin
      if (byte_idx == BW'(k)) cur_byte = shadow[8*k +: 8];
    end
  end

  assign bit_end = (cnt == CNT_MAX);

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      byte_idx  <= '0;
      shadow    <= '0;
      chk       <= '0;
      tx_serial <= 1'b1;
      tx_active <= 1'b0;
      tx_done   <= 1'b0;
      pack_done <= 1'b0;
      busy      <= 1'b0;
    end else begin
      tx_done   <= 1'b0;
      pack_done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_en) begin
            shadow    <= bus.i_data;
            chk       <= chk_in;
            byte_idx  <= '0;
            cnt       <= '0;
            state     <= START;
            tx_serial <= 1'b0;
            tx_active <= 1'b1;
            busy      <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            cnt       <= '0;
            bit_idx   <= '0;
            state     <= DATA;
            tx_serial <= cur_byte[0];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              state     <= STOP;
              tx_serial <= 1'b1;
            end else begin
              bit_idx   <= bit_idx + 1'b1;
              tx_serial <= cur_byte[bit_idx + 3'd1];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          // Done flags are set one cycle early so they land on the final stop-bit cycle.
          if (cnt == CNT_PRE) begin
            tx_done   <= 1'b1;
            pack_done <= (byte_idx == LAST);
          end
          if (bit_end) begin
            cnt <= '0;
            if (byte_idx == LAST) begin
              state     <= IDLE;
              tx_active <= 1'b0;
              busy      <= 1'b0;
            end else begin
              byte_idx  <= byte_idx + 1'b1;
              state     <= START;
              tx_serial <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_busy      = busy;
  assign bus.o_Tx_Active = tx_active;
  assign bus.o_Tx_Serial = tx_serial;
  assign bus.o_Tx_Done   = tx_done;
  assign bus.o_pack_done = pack_done;
endmodule
